// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle controller (master) and its datapath (slave).
interface multi_cycle_control_if;
  logic [5:0] Opcode;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       PCWriteCondNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode,
    output PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal, State
  );

  modport slave (
    output Opcode,
    input  PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal, State
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style main controller; strobes are registered from the next state.
// Optional BNE support (opcode 0x05) is enabled by defining MULTI_CYCLE_CONTROL_BNE_EN.
module multi_cycle_control (
  input  logic                          clk,
  input  logic                          reset,
  multi_cycle_control_if.master         ctl
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_INIT   = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctl_t;

  state_t r_state;
  state_t w_next_state;
  ctl_t   r_ctl;
  ctl_t   w_next_ctl;
  logic   w_illegal;
  logic   w_bne_op;

`ifdef MULTI_CYCLE_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE = 6'h05;
  assign w_bne_op = (ctl.Opcode == OP_BNE);
`else
  assign w_bne_op = 1'b0;
`endif

  // Next-state decode; Illegal is the only output taken straight from Opcode in DECODE.
  always_comb begin
    w_next_state = S_FETCH;
    w_illegal    = 1'b0;
    case (r_state)
      S_INIT:   w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (ctl.Opcode)
          OP_RTYPE:       w_next_state = S_EXEC;
          OP_LW, OP_SW:   w_next_state = S_MEMADR;
          OP_BEQ:         w_next_state = S_BRANCH;
          OP_J:           w_next_state = S_JUMP;
          OP_ADDI, OP_ORI: w_next_state = S_IEXEC;
          default: begin
            w_next_state = w_bne_op ? S_BRANCH : S_FETCH;
            w_illegal    = ~w_bne_op;
          end
        endcase
      end
      S_MEMADR: w_next_state = (ctl.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next_state = S_MEMWB;
      S_EXEC:   w_next_state = S_RCOMP;
      S_IEXEC:  w_next_state = S_IWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Strobes for the state being entered, so the registered copy lines up with State.
  always_comb begin
    w_next_ctl = '0;
    case (w_next_state)
      S_FETCH: begin
        w_next_ctl.mem_read  = 1'b1;
        w_next_ctl.ir_write  = 1'b1;
        w_next_ctl.alu_src_b = 2'b01;
        w_next_ctl.alu_op    = ALU_ADD;
        w_next_ctl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        w_next_ctl.alu_src_b = 2'b11;
        w_next_ctl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        w_next_ctl.alu_src_a = 1'b1;
        w_next_ctl.alu_src_b = 2'b10;
        w_next_ctl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        w_next_ctl.mem_read = 1'b1;
        w_next_ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_next_ctl.mem_to_reg = 1'b1;
        w_next_ctl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_next_ctl.mem_write = 1'b1;
        w_next_ctl.iord      = 1'b1;
      end
      S_EXEC: begin
        w_next_ctl.alu_src_a = 1'b1;
        w_next_ctl.alu_op    = ALU_RTYPE;
      end
      S_RCOMP: begin
        w_next_ctl.reg_dst   = 1'b1;
        w_next_ctl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_next_ctl.alu_src_a        = 1'b1;
        w_next_ctl.alu_op           = ALU_SUB;
        w_next_ctl.pc_source        = 2'b01;
        w_next_ctl.pc_write_cond    = (ctl.Opcode == OP_BEQ);
        w_next_ctl.pc_write_cond_ne = w_bne_op;
      end
      S_JUMP: begin
        w_next_ctl.pc_source = 2'b10;
        w_next_ctl.pc_write  = 1'b1;
      end
      S_IEXEC: begin
        w_next_ctl.alu_src_a = 1'b1;
        w_next_ctl.alu_src_b = 2'b10;
        w_next_ctl.alu_op    = (ctl.Opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IWB:   w_next_ctl.reg_write = 1'b1;
      default: w_next_ctl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_ctl   <= '0;
    end else begin
      r_state <= w_next_state;
      r_ctl   <= w_next_ctl;
    end
  end

  assign ctl.PCWrite       = r_ctl.pc_write;
  assign ctl.PCWriteCond   = r_ctl.pc_write_cond;
  assign ctl.PCWriteCondNE = r_ctl.pc_write_cond_ne;
  assign ctl.IorD          = r_ctl.iord;
  assign ctl.MemRead       = r_ctl.mem_read;
  assign ctl.MemWrite      = r_ctl.mem_write;
  assign ctl.IRWrite       = r_ctl.ir_write;
  assign ctl.MemtoReg      = r_ctl.mem_to_reg;
  assign ctl.RegWrite      = r_ctl.reg_write;
  assign ctl.RegDst        = r_ctl.reg_dst;
  assign ctl.ALUSrcA       = r_ctl.alu_src_a;
  assign ctl.ALUSrcB       = r_ctl.alu_src_b;
  assign ctl.PCSource      = r_ctl.pc_source;
  assign ctl.ALUOp         = r_ctl.alu_op;
  assign ctl.Illegal       = w_illegal;
  assign ctl.State         = r_state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized instruction stream against a per-instruction state-path and strobe-table model.
module tb_multi_cycle_control;

`ifdef MULTI_CYCLE_CONTROL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       pcwcne;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rw;
    logic       rd;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic [2:0] aop;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  multi_cycle_control_if bus ();

  multi_cycle_control dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(logic [5:0] op);
    case (op)
      6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D: return 1'b1;
      6'h05:   return BNE_EN;
      default: return 1'b0;
    endcase
  endfunction

  // State path of one instruction, starting at FETCH entry.
  function automatic void build_path(input logic [5:0] op, output int q[$]);
    q = {0, 1};
    case (op)
      6'h00: q = {q, 6, 7};
      6'h23: q = {q, 2, 3, 4};
      6'h2B: q = {q, 2, 5};
      6'h04: q = {q, 8};
      6'h02: q = {q, 9};
      6'h08, 6'h0D: q = {q, 10, 11};
      6'h05: if (BNE_EN) q = {q, 8};
      default: ;
    endcase
  endfunction

  // Strobe table: which signals the spec lists for each state of a given instruction.
  function automatic ctl_t exp_ctl(int st, logic [5:0] op);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.mr = 1; c.irw = 1; c.asb = 2'b01; c.aop = 3'b100; c.pcw = 1; end
      1:  begin c.asb = 2'b11; c.aop = 3'b100; c.ill = !is_legal(op); end
      2:  begin c.asa = 1; c.asb = 2'b10; c.aop = 3'b100; end
      3:  begin c.mr = 1; c.iord = 1; end
      4:  begin c.m2r = 1; c.rw = 1; end
      5:  begin c.mw = 1; c.iord = 1; end
      6:  begin c.asa = 1; c.aop = 3'b111; end
      7:  begin c.rd = 1; c.rw = 1; end
      8:  begin c.asa = 1; c.aop = 3'b110; c.pcs = 2'b01;
                c.pcwc = (op == 6'h04); c.pcwcne = BNE_EN && (op == 6'h05); end
      9:  begin c.pcs = 2'b10; c.pcw = 1; end
      10: begin c.asa = 1; c.asb = 2'b10; c.aop = (op == 6'h0D) ? 3'b101 : 3'b100; end
      11: c.rw = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t observed();
    ctl_t c;
    c = {bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNE, bus.IorD, bus.MemRead,
         bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
         bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.Illegal};
    return c;
  endfunction

  task automatic check(input string tag, input int exp_st, input ctl_t exp_c);
    ctl_t obs;
    obs = observed();
    n_cmp++;
    assert (bus.State === 4'(exp_st)) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, bus.State, exp_st);
    end
    n_cmp++;
    assert (obs === exp_c) else begin
      n_fail++;
      $error("FAIL %s strobes(st=%0d): observed %h expected %h", tag, exp_st, obs, exp_c);
    end
  endtask

  // Entered at posedge+1 in FETCH; leaves at posedge+1 in the next FETCH (or after n_max states).
  task automatic run_instr(input logic [5:0] op, input bit wiggle, input int n_max);
    int q[$];
    int n;
    build_path(op, q);
    n = (n_max > 0 && n_max < q.size()) ? n_max : q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == 0)
        bus.Opcode = wiggle ? 6'($urandom) : bus.Opcode;
      else if (wiggle && (q[i] inside {3, 4, 5, 6, 7, 9, 11}))
        bus.Opcode = 6'($urandom);
      else
        bus.Opcode = op;
      @(negedge clk);
      check($sformatf("op%02h", op), q[i], exp_ctl(q[i], op));
    end
    if (n == q.size()) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] dir_ops[10];
    logic [5:0] pool[10];
    logic [5:0] op;
    dir_ops = '{6'h23, 6'h00, 6'h0D, 6'h08, 6'h05, 6'h3F, 6'h2B, 6'h04, 6'h02, 6'h05};
    pool    = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0D, 6'h3F, 6'h01};
    bus.Opcode = 6'h00;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1 check("rst_async", 15, '0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold", 15, '0);
    end
    reset = 1'b1;
    #1 check("rst_release", 15, '0);
    @(posedge clk);
    #1 check("first_fetch", 0, exp_ctl(0, 6'h00));

    foreach (dir_ops[i]) run_instr(dir_ops[i], 1'b0, 0);

    // Reset abandons a load while in MEMRD.
    run_instr(6'h23, 1'b0, 4);
    #2 reset = 1'b0;
    #1 check("rst_memrd", 15, '0);
    @(posedge clk);
    #1 check("rst_memrd_hold", 15, '0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_memrd_rel", 15, '0);
    @(posedge clk);
    #1 check("rst_memrd_fetch", 0, exp_ctl(0, 6'h00));

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 7) op = pool[$urandom_range(0, 9)];
      else op = 6'($urandom);
      run_instr(op, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL have no parameters; opcode values and ALUOp codes SHALL be fixed localparams.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Opcode  input  6  instruction[31:26], taken from the instruction register and stable from the FETCH write until the next FETCH.
REQ-005 PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-006 ALUSrcB  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-007 PCSource  output  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-008 ALUOp  output  3  ALU control code: 111 R-type (use funct), 100 add, 101 or, 110 sub.
REQ-009 Illegal  output  1  one-cycle pulse for an unsupported opcode.
REQ-010 State  output  4  current state encoding, for debug.

Function
REQ-011 States and encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, INIT=15.
REQ-012 Any output not listed for a state SHALL be 0 in that state.
REQ-013 INIT: all outputs 0; next state FETCH unconditionally.
REQ-014 FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=100, PCWrite=1; next state DECODE.
REQ-015 DECODE: ALUSrcB=11, ALUOp=100; next state by Opcode:
- 0x00 -> EXEC
- 0x23 or 0x2B -> MEMADR
- 0x04 -> BRANCH
- 0x02 -> JUMP
- 0x08 or 0x0D -> IEXEC
- any other -> FETCH with Illegal=1 in DECODE.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=100; next state MEMRD if Opcode=0x23, else MEMWR.
REQ-017 MEMRD: MemRead=1, IorD=1; next state MEMWB. MEMWB: MemtoReg=1, RegWrite=1; next state FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; next state FETCH.
REQ-019 EXEC: ALUSrcA=1, ALUOp=111; next state RCOMP. RCOMP: RegDst=1, RegWrite=1; next state FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUOp=110, PCSource=01, PCWriteCond=1 when Opcode=0x04, PCWriteCondNE=1 when Opcode=0x05; next state FETCH.
REQ-021 JUMP: PCSource=10, PCWrite=1; next state FETCH.
REQ-022 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=100 when Opcode=0x08 and 101 when Opcode=0x0D; next state IWB. IWB: RegWrite=1; next state FETCH.
REQ-023 Cycles per instruction from FETCH entry SHALL be: LW 5, SW 4, R 4, ADDI/ORI 4, BEQ/BNE 3, J 3, illegal 2.
REQ-024 Outputs other than Illegal, PCWriteCond/NE and IEXEC ALUOp SHALL depend on State only; none of them SHALL glitch on Opcode changes outside DECODE/MEMADR/BRANCH/IEXEC.
REQ-025 Unused encodings 12-14 SHALL drive all outputs 0 and go to FETCH next cycle.

Reset
REQ-026 reset low SHALL force State=INIT immediately, independent of clk, with all outputs 0.
REQ-027 Reset asserted mid-instruction SHALL abandon that instruction; no write strobe SHALL be asserted while reset is low.
REQ-028 The first rising edge after release SHALL move the block INIT->FETCH.

Configuration
REQ-029 Macro MULTI_CYCLE_CONTROL_BNE_EN:
- defined: opcode 0x05 in DECODE -> BRANCH, as in REQ-020.
- undefined: 0x05 is illegal (REQ-015), and PCWriteCondNE SHALL be tied 0.

Verification
REQ-030 Assert reset low during MEMRD, release -> State=15 with all outputs 0, then State=0 on the next edge.
REQ-031 Opcode=0x23 -> States 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4.
REQ-032 Opcode=0x00 -> States 0,1,6,7,0; ALUOp=111 in state 6; RegDst=1 in state 7.
REQ-033 Opcode=0x0D -> IEXEC ALUOp=101. Opcode=0x08 -> IEXEC ALUOp=100. Both are followed by IWB with RegWrite=1.
REQ-034 Opcode=0x05 with BNE_EN defined -> PCWriteCondNE=1 and ALUOp=110 in state 8. Opcode=0x05 with BNE_EN undefined -> Illegal=1 in state 1, then State=0.
REQ-035 Opcode=0x3F -> Illegal=1 for exactly one cycle, no write strobe asserted, return to FETCH after 2 cycles.
